// File: rtl/mem_request_scheduler.sv
// Round-robin scheduler sharing one main-memory port between three requesters,
// with bounded burst locking and a sticky watchdog on a stalled memory port.
module mem_request_scheduler #(
    parameter int NREQ      = 3,
    parameter int BURST_MAX = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NREQ-1:0]       req_ren,
    input  logic [NREQ-1:0]       req_wen,
    input  logic [NREQ-1:0]       req_lock,
    input  logic [NREQ-1:0][31:0] req_addr,
    input  logic [NREQ-1:0][31:0] req_store,
    output logic [NREQ-1:0][31:0] req_load,
    output logic [NREQ-1:0]       req_wait,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  logic                  ramBUSY,
    output logic                  err_timeout,
    output logic [0:0]            dbg_state,
    output logic [1:0]            dbg_grant,
    output logic [1:0]            dbg_rr_ptr
);

    localparam logic [0:0] IDLE       = 1'b0;
    localparam logic [0:0] ACCESS     = 1'b1;
    localparam logic [1:0] BURST_LAST = 2'(BURST_MAX - 1);
    localparam logic [7:0] WD_LIMIT   = 8'(TIMEOUT);

    logic [0:0]      state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [1:0]      burst_cnt_q, burst_cnt_d;
    logic [7:0]      wd_cnt_q, wd_cnt_d;
    logic            err_q, err_d;
    logic [NREQ-1:0] req_any;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // First requesting port scanning from ptr upwards, modulo 3.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [1:0] p1;
        logic [1:0] p2;
        p1 = next_port(ptr);
        p2 = next_port(p1);
        if (req[ptr]) return ptr;
        else if (req[p1]) return p1;
        else return p2;
    endfunction

    assign req_any = req_ren | req_wen;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        err_d       = err_q;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        req_load    = '0;
        req_wait    = req_any;
        case (state_q)
            IDLE: begin
                if (|req_any) begin
                    grant_d     = rr_pick(req_any, rr_ptr_q);
                    burst_cnt_d = '0;
                    wd_cnt_d    = '0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                // Write wins when a requester raises both enables.
                ramWEN   = req_wen[grant_q];
                ramREN   = req_ren[grant_q] & ~req_wen[grant_q];
                ramaddr  = req_addr[grant_q];
                ramstore = req_store[grant_q];
                if (!req_any[grant_q]) begin
                    rr_ptr_d = next_port(grant_q);
                    state_d  = IDLE;
                end else if (!ramBUSY) begin
                    req_wait[grant_q] = 1'b0;
                    req_load[grant_q] = ramload;
                    wd_cnt_d          = '0;
                    if (req_lock[grant_q] && (burst_cnt_q < BURST_LAST)) begin
                        burst_cnt_d = burst_cnt_q + 2'd1;
                    end else begin
                        rr_ptr_d = next_port(grant_q);
                        state_d  = IDLE;
                    end
                end else begin
                    if (wd_cnt_q != 8'hFF) wd_cnt_d = wd_cnt_q + 8'd1;
                    if (wd_cnt_d == WD_LIMIT) err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            wd_cnt_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            err_q       <= err_d;
        end
    end

    assign err_timeout = err_q;
    assign dbg_state   = state_q;
    assign dbg_grant   = grant_q;
    assign dbg_rr_ptr  = rr_ptr_q;

endmodule

// File: tb/tb_mem_request_scheduler.sv
// Bench for mem_request_scheduler: per-port request drivers, a latency-programmable
// memory model and a scoreboard of expected completions in grant order.
module tb_mem_request_scheduler;

    localparam int W = 68;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [2:0]       req_ren, req_wen, req_lock;
    logic [2:0][31:0] req_addr, req_store, req_load;
    logic [2:0]       req_wait;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic             ramBUSY = 1'b0;
    logic             err_timeout;
    logic [0:0]       dbg_state;
    logic [1:0]       dbg_grant, dbg_rr_ptr;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int lat   = 0;
    int wait_cnt = 0;
    bit en_s = 1'b0, done_s = 1'b0;

    logic [W-1:0] exp_q[$];
    int           comp_cyc[$];

    mem_request_scheduler #(.NREQ(3), .BURST_MAX(4), .TIMEOUT(255)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_ren(req_ren), .req_wen(req_wen), .req_lock(req_lock),
        .req_addr(req_addr), .req_store(req_store),
        .req_load(req_load), .req_wait(req_wait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramBUSY(ramBUSY),
        .err_timeout(err_timeout),
        .dbg_state(dbg_state), .dbg_grant(dbg_grant), .dbg_rr_ptr(dbg_rr_ptr)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic do_reset();
        nRST = 1'b0;
        req_ren = '0; req_wen = '0; req_lock = '0;
        req_addr = '0; req_store = '0;
        lat = 0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        exp_q.delete();
        comp_cyc.delete();
    endtask

    // ---------------- memory model ----------------
    function automatic logic [31:0] load_of(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
    endfunction

    assign ramload = load_of(ramaddr);

    always @(negedge CLK) begin
        en_s   = ramREN | ramWEN;
        done_s = en_s && !ramBUSY;
    end

    // ramBUSY stays high for `lat` cycles of each access, then drops for one cycle.
    always @(posedge CLK) begin
        #1;
        if (!en_s || done_s) wait_cnt = 0;
        else wait_cnt++;
        ramBUSY = (wait_cnt < lat);
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rec(input int p, input bit wr, input logic [31:0] addr,
                                         input logic [31:0] store);
        return {2'(p), wr, !wr, addr, wr ? store : load_of(addr)};
    endfunction

    // Scoreboard: every completion seen on the DUT pops the next expected record.
    always @(negedge CLK) begin
        if (nRST) begin
            for (int p = 0; p < 3; p++) begin
                if ((req_ren[p] | req_wen[p]) && !req_wait[p]) begin
                    logic [W-1:0] obs;
                    logic [31:0]  others;
                    obs = {2'(p), ramWEN, ramREN, ramaddr, ramWEN ? ramstore : req_load[p]};
                    others = '0;
                    for (int q = 0; q < 3; q++) if (q != p) others = others | req_load[q];
                    comp_cyc.push_back(cyc);
                    check_eq("load_other_ports", W'(others), W'(0));
                    if (exp_q.size() == 0) check_eq("sb_unexpected", W'(exp_q.size()), W'(1));
                    else check_eq("sb_completion", obs, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_done(input int p, output int t);
        t = 0;
        forever begin
            @(negedge CLK);
            if (!req_wait[p]) break;
            t++;
            if (t > 600) begin
                check_eq("wait_bound", W'(t), W'(0));
                break;
            end
        end
    endtask

    task automatic port_seq(input int p, input int n, input bit wr, input bit lock,
                            input logic [31:0] base, output int max_t);
        int t;
        max_t = 0;
        for (int k = 0; k < n; k++) begin
            req_ren[p]   = !wr;
            req_wen[p]   = wr;
            req_lock[p]  = lock;
            req_addr[p]  = base + 32'(k * 4);
            req_store[p] = base ^ 32'(k);
            wait_done(p, t);
            if (t > max_t) max_t = t;
            @(posedge CLK);
            #1;
        end
        req_ren[p] = 1'b0; req_wen[p] = 1'b0; req_lock[p] = 1'b0;
    endtask

    // ---------------- tests ----------------
    initial begin
        int t, m0, m1, m2;

        // Reset state, with port 2 requesting to show req_wait is combinational.
        nRST = 1'b0;
        req_ren = 3'b100; req_wen = '0; req_lock = '0; req_addr = '0; req_store = '0;
        #3;
        check_eq("rst_mem_en", W'({ramREN, ramWEN}), W'(0));
        check_eq("rst_mem_bus", W'({ramaddr, ramstore}), W'(0));
        check_eq("rst_load", W'(|req_load), W'(0));
        check_eq("rst_regs", W'({err_timeout, dbg_state, dbg_grant, dbg_rr_ptr}), W'(0));
        check_eq("rst_wait", W'(req_wait), W'(3'b100));

        // Single read on port 1, two busy cycles.
        do_reset();
        lat = 2;
        exp_q.push_back(rec(1, 1'b0, 32'h40, 32'h40));
        port_seq(1, 1, 1'b0, 1'b0, 32'h40, t);
        check_eq("t1_wait_cycles", W'(t), W'(3));
        @(negedge CLK);
        check_eq("t1_rr_ptr", W'(dbg_rr_ptr), W'(2));
        check_eq("t1_sb_drained", W'(exp_q.size()), W'(0));

        // All three ports continuously, zero-wait memory, no lock.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 3; p++)
                exp_q.push_back(rec(p, 1'b0, 32'h1000 * (p + 1) + 32'(r * 4), 32'h0));
        fork
            port_seq(0, 2, 1'b0, 1'b0, 32'h1000, m0);
            port_seq(1, 2, 1'b0, 1'b0, 32'h2000, m1);
            port_seq(2, 2, 1'b0, 1'b0, 32'h3000, m2);
        join
        check_eq("t2_count", W'(comp_cyc.size()), W'(6));
        for (int i = 1; i < comp_cyc.size(); i++)
            check_eq("t2_gap", W'(comp_cyc[i] - comp_cyc[i-1]), W'(2));
        check_eq("t2_max_wait", W'((m0 <= 6) && (m1 <= 6) && (m2 <= 6)), W'(1));

        // Port 1 locked burst of 6 writes while port 0 waits.
        do_reset();
        for (int k = 0; k < 4; k++) exp_q.push_back(rec(1, 1'b1, 32'h100 + 32'(k * 4), 32'h100 ^ 32'(k)));
        exp_q.push_back(rec(0, 1'b0, 32'h200, 32'h0));
        for (int k = 4; k < 6; k++) exp_q.push_back(rec(1, 1'b1, 32'h100 + 32'(k * 4), 32'h100 ^ 32'(k)));
        fork
            port_seq(1, 6, 1'b1, 1'b1, 32'h100, m1);
            begin
                @(posedge CLK);
                #1;
                port_seq(0, 1, 1'b0, 1'b0, 32'h200, m0);
            end
        join
        check_eq("t3_count", W'(comp_cyc.size()), W'(7));
        if (comp_cyc.size() == 7) begin
            for (int i = 1; i < 4; i++)
                check_eq("t3_burst_gap", W'(comp_cyc[i] - comp_cyc[i-1]), W'(1));
            check_eq("t3_handover_gap", W'(comp_cyc[4] - comp_cyc[3]), W'(2));
        end

        // Port 2 raises both enables: write wins.
        do_reset();
        exp_q.push_back(rec(2, 1'b1, 32'h10, 32'h5));
        req_ren[2] = 1'b1; req_wen[2] = 1'b1; req_addr[2] = 32'h10; req_store[2] = 32'h5;
        wait_done(2, t);
        check_eq("t4_wait_cycles", W'(t), W'(1));
        @(posedge CLK);
        #1 req_ren[2] = 1'b0; req_wen[2] = 1'b0;

        // Stuck memory: watchdog, then asynchronous reset mid-access.
        do_reset();
        lat = 1000;
        req_ren[0] = 1'b1; req_addr[0] = 32'h80;
        repeat (200) @(negedge CLK);
        check_eq("t5_err_early", W'(err_timeout), W'(0));
        repeat (100) @(negedge CLK);
        check_eq("t5_err_set", W'(err_timeout), W'(1));
        check_eq("t5_still_waiting", W'({ramREN, req_wait[0], ramaddr}), W'({2'b11, 32'h80}));
        repeat (5) @(negedge CLK);
        check_eq("t5_err_sticky", W'(err_timeout), W'(1));
        #2 nRST = 1'b0;
        #1;
        check_eq("t5_rst_mem", W'({ramREN, ramWEN, ramaddr, ramstore}), W'(0));
        check_eq("t5_rst_err", W'(err_timeout), W'(0));
        req_ren[0] = 1'b0;
        exp_q.delete();
        comp_cyc.delete();

        // Port 0 aborts mid-access.
        do_reset();
        lat = 1000;
        req_ren[0] = 1'b1; req_addr[0] = 32'h20;
        repeat (3) @(negedge CLK);
        check_eq("t6_in_access", W'(dbg_state), W'(1));
        @(posedge CLK);
        #1 req_ren[0] = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check_eq("t6_idle", W'(dbg_state), W'(0));
        check_eq("t6_rr_ptr", W'(dbg_rr_ptr), W'(1));
        check_eq("t6_no_completion", W'(comp_cyc.size()), W'(0));

        check_eq("sb_leftover", W'(exp_q.size()), W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
